// File: rtl/esm_issue_scheduler_if.sv
// Fetch-side and issue-side handshake bundle for the ESM issue scheduler.
// The master is the upstream/consumer side and the slave is the scheduler.
interface esm_issue_scheduler_if #(
    parameter int IW = 32,
    parameter int BS = 16
) ();
    localparam int BB = $clog2(BS);

    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic          in_ready;
    logic [BS-1:0] entry_ready;
    logic          issue_valid;
    logic          issue_ready;
    logic [IW-1:0] issue_instr;
    logic [BB-1:0] issue_idx;

    modport master (
        output in_valid, in_instr, entry_ready, issue_ready,
        input  in_ready, issue_valid, issue_instr, issue_idx
    );

    modport slave (
        input  in_valid, in_instr, entry_ready, issue_ready,
        output in_ready, issue_valid, issue_instr, issue_idx
    );
endinterface

// File: rtl/esm_issue_scheduler.sv
// ESM instruction window: fills a bs-entry buffer, then issues ready entries round-robin.
// Optional ESM_SCHED_STATS_EN adds saturating issue/stall counters.
module esm_issue_scheduler #(
    parameter  int Instruction_word_size = 32,
    parameter  int bs                    = 16,
    localparam int bs_bits               = $clog2(bs)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    esm_issue_scheduler_if.slave bus,
    output logic [bs-1:0]        valid_entries,
    output logic [bs_bits:0]     count,
    output logic [1:0]           sched_state
`ifdef ESM_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);
    localparam int IW = Instruction_word_size;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_SELECT = 2'd1,
        S_GRANT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [bs_bits-1:0]   wr_ptr_q, wr_ptr_d;
    logic [bs_bits-1:0]   rr_ptr_q, rr_ptr_d;
    logic [bs-1:0]        valid_q, valid_d;
    logic [bs_bits:0]     count_q, count_d;
    logic                 issue_valid_q, issue_valid_d;
    logic [bs_bits-1:0]   issue_idx_q, issue_idx_d;
    logic [IW-1:0]        issue_instr_q, issue_instr_d;

    logic [IW-1:0]        mem [bs];
    logic                 wr_en;
    logic                 fire;
    logic [bs-1:0]        cand;
    logic [bs-1:0]        cand_rot;
    logic [bs_bits-1:0]   scan_idx [bs];
    logic                 found;
    logic [bs_bits-1:0]   pick;

    assign cand = valid_q & bus.entry_ready;
    assign fire = (state_q == S_GRANT) && issue_valid_q && bus.issue_ready;

    // Rotate the candidate mask so position 0 is the round-robin pointer.
    for (genvar gi = 0; gi < bs; gi++) begin : g_rot
        assign scan_idx[gi] = rr_ptr_q + bs_bits'(gi);
        assign cand_rot[gi] = cand[scan_idx[gi]];
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < bs; k++) begin
            if (!found && cand_rot[k]) begin
                found = 1'b1;
                pick  = scan_idx[k];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rr_ptr_d      = rr_ptr_q;
        valid_d       = valid_q;
        count_d       = count_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        issue_instr_d = issue_instr_q;
        bus.in_ready  = 1'b0;
        wr_en         = 1'b0;

        case (state_q)
            S_FILL: begin
                bus.in_ready = (count_q < (bs_bits+1)'(bs));
                wr_en        = bus.in_valid && bus.in_ready;
                if (wr_en) begin
                    valid_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d          = wr_ptr_q + 1'b1;
                    count_d           = count_q + 1'b1;
                    if (count_q == (bs_bits+1)'(bs - 1)) state_d = S_SELECT;
                end else if (count_q == (bs_bits+1)'(bs)) begin
                    state_d = S_SELECT;
                end else if (!bus.in_valid && count_q != '0) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (found) begin
                    issue_idx_d   = pick;
                    issue_instr_d = mem[pick];
                    issue_valid_d = 1'b1;
                    state_d       = S_GRANT;
                end
            end
            S_GRANT: begin
                if (fire) begin
                    valid_d[issue_idx_q] = 1'b0;
                    count_d              = count_q - 1'b1;
                    rr_ptr_d             = issue_idx_q + 1'b1;
                    issue_valid_d        = 1'b0;
                    if (count_q == (bs_bits+1)'(1)) begin
                        state_d  = S_FILL;
                        wr_ptr_d = '0;
                        rr_ptr_d = '0;
                    end else begin
                        state_d = S_SELECT;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase

        // Flush wins over everything except reset; buffer contents are simply abandoned.
        if (flush) begin
            state_d       = S_FILL;
            wr_ptr_d      = '0;
            rr_ptr_d      = '0;
            valid_d       = '0;
            count_d       = '0;
            issue_valid_d = 1'b0;
            issue_idx_d   = '0;
            issue_instr_d = '0;
            wr_en         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.in_instr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_FILL;
            wr_ptr_q      <= '0;
            rr_ptr_q      <= '0;
            valid_q       <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            issue_instr_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rr_ptr_q      <= rr_ptr_d;
            valid_q       <= valid_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            issue_instr_q <= issue_instr_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_idx   = issue_idx_q;
    assign bus.issue_instr = issue_instr_q;
    assign valid_entries   = valid_q;
    assign count           = count_q;
    assign sched_state     = state_q;

`ifdef ESM_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (fire && stat_issued_q != '1) stat_issued_d = stat_issued_q + 1'b1;
        if (state_q == S_SELECT && cand == '0 && stat_stall_q != '1)
            stat_stall_d = stat_stall_q + 1'b1;
    end

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif
endmodule
